// File: rtl/melody_sequencer.sv
// Fixed 25-entry melody sequencer: LOAD/NOTE/SPACE FSM stepping a note ROM on a tick timebase.
// Optional feature macro MELODY_TEMPO_SEL_EN adds a 2-bit tempo input (tick period = TICK_CYCLES >> tempo).
module melody_sequencer #(
  parameter int unsigned TICK_CYCLES = 683593
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       restart,
`ifdef MELODY_TEMPO_SEL_EN
  input  logic [1:0] tempo,
`endif
  output logic [2:0] note,
  output logic       gate,
  output logic       note_start,
  output logic [4:0] melody_pos,
  output logic       loop_done
);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_NOTE  = 2'd1,
    S_SPACE = 2'd2
  } state_t;

  localparam logic [19:0] TICK_W = 20'(TICK_CYCLES);

  // ROM entry as {note[2:0], long}
  function automatic logic [3:0] rom_entry(input logic [4:0] idx);
    logic [3:0] v;
    case (idx)
      5'd0:    v = {3'd1, 1'b1};
      5'd1:    v = {3'd0, 1'b1};
      5'd2:    v = {3'd3, 1'b0};
      5'd3:    v = {3'd2, 1'b1};
      5'd4:    v = {3'd5, 1'b0};
      5'd5:    v = {3'd3, 1'b0};
      5'd6:    v = {3'd4, 1'b0};
      5'd7:    v = {3'd5, 1'b1};
      5'd8:    v = {3'd5, 1'b1};
      5'd9:    v = {3'd4, 1'b1};
      5'd10:   v = {3'd3, 1'b1};
      5'd11:   v = {3'd3, 1'b0};
      5'd12:   v = {3'd4, 1'b0};
      5'd13:   v = {3'd5, 1'b0};
      5'd14:   v = {3'd4, 1'b0};
      5'd15:   v = {3'd2, 1'b0};
      5'd16:   v = {3'd1, 1'b0};
      5'd17:   v = {3'd0, 1'b0};
      5'd18:   v = {3'd2, 1'b0};
      5'd19:   v = {3'd1, 1'b0};
      5'd20:   v = {3'd4, 1'b0};
      5'd21:   v = {3'd3, 1'b0};
      5'd22:   v = {3'd5, 1'b0};
      5'd23:   v = {3'd4, 1'b0};
      5'd24:   v = {3'd5, 1'b0};
      default: v = {3'd1, 1'b1};
    endcase
    return v;
  endfunction

  state_t      r_state, w_state_nxt;
  logic [19:0] r_tick_cnt, w_tick_cnt_nxt;
  logic [2:0]  r_dur_cnt, w_dur_cnt_nxt;
  logic [4:0]  r_pos, w_pos_nxt;
  logic [2:0]  r_note, w_note_nxt;
  logic        r_note_start, w_note_start_nxt;
  logic        r_loop_done, w_loop_done_nxt;
  logic [19:0] w_period;
  logic        w_tick;
  logic [3:0]  w_entry;
  logic [3:0]  w_entry_next;
  logic [4:0]  w_pos_inc;
  logic [2:0]  w_dur_limit;

  assign w_tick = run && (r_state != S_LOAD) && (r_tick_cnt == (w_period - 20'd1));

`ifdef MELODY_TEMPO_SEL_EN
  logic [1:0]  r_tempo;
  logic [19:0] w_shift;

  assign w_shift  = TICK_W >> r_tempo;
  assign w_period = (w_shift == 20'd0) ? 20'd1 : w_shift;

  // Tempo only changes at tick boundaries or while waiting in LOAD
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tempo <= 2'd0;
    end else if ((r_state == S_LOAD) || w_tick) begin
      r_tempo <= tempo;
    end else begin
      r_tempo <= r_tempo;
    end
  end
`else
  assign w_period = TICK_W;
`endif

  assign w_entry      = rom_entry(r_pos);
  assign w_pos_inc    = (r_pos == 5'd24) ? 5'd0 : (r_pos + 5'd1);
  assign w_entry_next = rom_entry(w_pos_inc);
  assign w_dur_limit  = w_entry[0] ? 3'd6 : 3'd2;

  // Next-state and next-value logic; restart overrides everything else
  always_comb begin
    w_state_nxt      = r_state;
    w_tick_cnt_nxt   = r_tick_cnt;
    w_dur_cnt_nxt    = r_dur_cnt;
    w_pos_nxt        = r_pos;
    w_note_nxt       = r_note;
    w_note_start_nxt = 1'b0;
    w_loop_done_nxt  = 1'b0;
    if (restart) begin
      w_state_nxt    = S_LOAD;
      w_tick_cnt_nxt = 20'd0;
      w_dur_cnt_nxt  = 3'd0;
      w_pos_nxt      = 5'd0;
      w_note_nxt     = 3'd1;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (run) begin
            w_state_nxt      = S_NOTE;
            w_tick_cnt_nxt   = 20'd0;
            w_dur_cnt_nxt    = 3'd0;
            w_note_start_nxt = 1'b1;
          end else begin
            w_state_nxt = S_LOAD;
          end
        end
        S_NOTE: begin
          if (!run) begin
            w_state_nxt = S_NOTE;
          end else if (w_tick) begin
            w_tick_cnt_nxt = 20'd0;
            if (r_dur_cnt == w_dur_limit) begin
              w_state_nxt   = S_SPACE;
              w_dur_cnt_nxt = 3'd0;
            end else begin
              w_dur_cnt_nxt = r_dur_cnt + 3'd1;
            end
          end else begin
            w_tick_cnt_nxt = r_tick_cnt + 20'd1;
          end
        end
        S_SPACE: begin
          if (!run) begin
            w_state_nxt = S_SPACE;
          end else if (w_tick) begin
            w_tick_cnt_nxt   = 20'd0;
            w_state_nxt      = S_NOTE;
            w_pos_nxt        = w_pos_inc;
            w_note_nxt       = w_entry_next[3:1];
            w_note_start_nxt = 1'b1;
            w_loop_done_nxt  = (r_pos == 5'd24);
          end else begin
            w_tick_cnt_nxt = r_tick_cnt + 20'd1;
          end
        end
        default: begin
          w_state_nxt    = S_LOAD;
          w_tick_cnt_nxt = 20'd0;
          w_dur_cnt_nxt  = 3'd0;
          w_pos_nxt      = 5'd0;
          w_note_nxt     = 3'd1;
        end
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_LOAD;
      r_tick_cnt   <= 20'd0;
      r_dur_cnt    <= 3'd0;
      r_pos        <= 5'd0;
      r_note       <= 3'd1;
      r_note_start <= 1'b0;
      r_loop_done  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_tick_cnt   <= w_tick_cnt_nxt;
      r_dur_cnt    <= w_dur_cnt_nxt;
      r_pos        <= w_pos_nxt;
      r_note       <= w_note_nxt;
      r_note_start <= w_note_start_nxt;
      r_loop_done  <= w_loop_done_nxt;
    end
  end

  assign note       = r_note;
  assign gate       = (r_state == S_NOTE) && run;
  assign note_start = r_note_start;
  assign melody_pos = r_pos;
  assign loop_done  = r_loop_done;

endmodule

// File: tb/tb_melody_sequencer.sv
// Scoreboard bench for melody_sequencer at TICK_CYCLES=4: expected notes are queued, popped on each note_start.
module tb_melody_sequencer;

  localparam int P = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic       restart = 1'b0;
`ifdef MELODY_TEMPO_SEL_EN
  logic [1:0] tempo = 2'd0;
`endif
  logic [2:0] note;
  logic       gate;
  logic       note_start;
  logic [4:0] melody_pos;
  logic       loop_done;

  melody_sequencer #(.TICK_CYCLES(P)) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .restart    (restart),
`ifdef MELODY_TEMPO_SEL_EN
    .tempo      (tempo),
`endif
    .note       (note),
    .gate       (gate),
    .note_start (note_start),
    .melody_pos (melody_pos),
    .loop_done  (loop_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pos;
    int nt;
    int ld;
    int hi;
    int lo;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   ld_cnt   = 0;

  int rom_note[25] = '{1, 0, 3, 2, 5, 3, 4, 5, 5, 4, 3, 3, 4, 5, 4, 2, 1, 0, 2, 1, 4, 3, 5, 4, 5};
  int rom_long[25] = '{1, 1, 0, 1, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

  always @(negedge clk) if (loop_done) ld_cnt++;

  task automatic check_val(input string tag, input int obs, input int expv);
    n_checks++;
    if (obs != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic void push_entry(input int idx, input int ld, input int p);
    exp_t e;
    e.pos = idx;
    e.nt  = rom_note[idx];
    e.ld  = ld;
    e.hi  = (rom_long[idx] != 0) ? 7 * p : 3 * p;
    e.lo  = p;
    exp_q.push_back(e);
  endfunction

  task automatic wait_ns(input int budget);
    bit got = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (note_start) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check_val("note_start_timeout", 0, 1);
  endtask

  // Called at a sample point where note_start should be high
  task automatic play_note(input bit measure);
    exp_t e;
    int hi;
    int lo;
    if (exp_q.size() == 0) begin
      check_val("queue_empty", 0, 1);
      return;
    end
    e = exp_q.pop_front();
    check_val($sformatf("note_start[%0d]", e.pos), int'(note_start), 1);
    check_val($sformatf("pos[%0d]", e.pos), int'(melody_pos), e.pos);
    check_val($sformatf("note[%0d]", e.pos), int'(note), e.nt);
    check_val($sformatf("loop_done[%0d]", e.pos), int'(loop_done), e.ld);
    if (measure) begin
      hi = 0;
      while (gate && hi < 200) begin
        hi++;
        @(negedge clk);
      end
      check_val($sformatf("gate_hi[%0d]", e.pos), hi, e.hi);
      lo = 0;
      while (!note_start && lo < 200) begin
        lo++;
        @(negedge clk);
      end
      check_val($sformatf("space[%0d]", e.pos), lo, e.lo);
    end
  endtask

  initial begin
    time t0;
    int  hi;
    int  lo;

    // Reset holds everything idle even with run requested
    run = 1'b1;
    repeat (3) @(negedge clk);
    check_val("rst_note", int'(note), 1);
    check_val("rst_pos", int'(melody_pos), 0);
    check_val("rst_gate", int'(gate), 0);
    check_val("rst_note_start", int'(note_start), 0);
    check_val("rst_loop_done", int'(loop_done), 0);

    // One full loop plus the wrap back to entry 0
    for (int i = 0; i < 25; i++) push_entry(i, 0, P);
    push_entry(0, 1, P);
    rst = 1'b0;
    wait_ns(4);
    t0 = $time;
    for (int i = 0; i < 25; i++) play_note(1'b1);
    play_note(1'b0);
    check_val("loop_cycles", int'(($time - t0) / 10), 512);
    #1;
    check_val("ld_cnt_loop", ld_cnt, 1);

    // Pause 5 cycles into entry 0
    for (int k = 0; k < 5; k++) begin
      check_val("pre_pause_gate", int'(gate), 1);
      @(negedge clk);
    end
    run = 1'b0;
    for (int k = 0; k < 10; k++) begin
      #1;
      check_val("pause_gate", int'(gate), 0);
      check_val("pause_pos", int'(melody_pos), 0);
      @(negedge clk);
    end
    run = 1'b1;
    #1;
    hi = 0;
    while (gate && hi < 200) begin
      hi++;
      @(negedge clk);
      #1;
    end
    check_val("resume_hi", hi, 23);
    lo = 0;
    while (!note_start && lo < 200) begin
      lo++;
      @(negedge clk);
      #1;
    end
    check_val("resume_space", lo, P);

    // Entries 1..4 normally, then restart inside the space of entry 5
    for (int i = 1; i <= 5; i++) push_entry(i, 0, P);
    for (int i = 1; i <= 4; i++) play_note(1'b1);
    play_note(1'b0);
    hi = 0;
    while (gate && hi < 200) begin
      hi++;
      @(negedge clk);
    end
    check_val("gate_hi_e5", hi, 12);
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    #1;
    check_val("restart_pos", int'(melody_pos), 0);
    check_val("restart_gate", int'(gate), 0);
    check_val("restart_note", int'(note), 1);
    check_val("restart_ns", int'(note_start), 0);
    push_entry(0, 0, P);
    push_entry(1, 0, P);
    wait_ns(4);
    play_note(1'b1);
    play_note(1'b0);
    #1;
    check_val("ld_cnt_restart", ld_cnt, 1);

    // Reset mid-note drops the gate on the next cycle
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check_val("midrst_gate", int'(gate), 0);
    check_val("midrst_pos", int'(melody_pos), 0);
    check_val("midrst_note", int'(note), 1);
    rst = 1'b0;
    push_entry(0, 0, P);
    wait_ns(4);
    play_note(1'b0);

`ifdef MELODY_TEMPO_SEL_EN
    // Double tempo halves every duration
    rst = 1'b1;
    tempo = 2'd1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) push_entry(i, 0, P / 2);
    push_entry(3, 0, P / 2);
    wait_ns(4);
    for (int i = 0; i < 3; i++) play_note(1'b1);
    play_note(1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/melody_sequencer.md
MELODY_SEQUENCER -- requirements
Module: melody_sequencer

Interface
REQ-001 SHALL have parameter TICK_CYCLES, default 683593, clock cycles per tick (25 MHz x 28 s / 1024 ticks); legal range 2..2^20-1.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port run  input  1  1 = play, 0 = pause.
REQ-005 SHALL have port restart  input  1  synchronous single-cycle request to return to melody entry 0.
REQ-006 SHALL have port note  output  3  current note code: G#=0, F#=1, D#=2, D=3, C#=4, B=5.
REQ-007 SHALL have port gate  output  1  1 = tone shall sound; combinational, equal to (state==NOTE) AND run.
REQ-008 SHALL have port note_start  output  1  registered 1-cycle pulse in the first cycle of every NOTE state.
REQ-009 SHALL have port melody_pos  output  5  index of current melody entry, 0..24.
REQ-010 SHALL have port loop_done  output  1  registered 1-cycle pulse when melody_pos wraps from 24 to 0.

Function
REQ-011 SHALL hold a fixed 25-entry ROM of {note, length}, 1 = long: F#L, G#L, DS, D#L, BS, DS, C#S, BL, BL, C#L, DL, DS, C#S, BS, C#S, D#S, F#S, G#S, D#S, F#S, C#S, DS, BS, C#S, BS.
REQ-012 SHALL implement states LOAD, NOTE and SPACE.
REQ-013 SHALL count tick_cnt (20 bits) 0..P-1 only while run=1 and state is NOTE or SPACE; P = tick period; a tick occurs when tick_cnt==P-1, and tick_cnt then returns to 0.
REQ-014 LOAD: gate=0; when run=1, SHALL go to NOTE next cycle, clear tick_cnt and dur_cnt, and assert note_start.
REQ-015 NOTE: dur_cnt SHALL increment per tick; on the tick where dur_cnt equals 2 (short) or 6 (long), SHALL go to SPACE and clear dur_cnt. Sounding time is 3P or 7P cycles.
REQ-016 SPACE: gate=0 for exactly one tick, then SHALL advance melody_pos (24 wraps to 0), go to NOTE, and assert note_start. On wrap, loop_done SHALL pulse in the same cycle as note_start.
REQ-017 note SHALL update in the same cycle melody_pos updates and remain stable for the whole NOTE and SPACE period.
REQ-018 run=0 SHALL freeze state, tick_cnt, dur_cnt and melody_pos and force gate=0; on resume, the remaining duration is unchanged.
REQ-019 restart=1 SHALL set melody_pos=0, state=LOAD and clear the counters, overriding a coincident tick, wrap or pause. loop_done SHALL NOT pulse on restart.
REQ-020 One full loop SHALL be 128 ticks (7 long x 8 + 18 short x 4).

Reset
REQ-021 rst=1 SHALL set state=LOAD, melody_pos=0, tick_cnt=0, dur_cnt=0, note=1 (F#), note_start=0, loop_done=0, gate=0.
REQ-022 rst SHALL take priority over restart and run; asserting rst mid-note SHALL force gate=0 in the next cycle.

Configuration
REQ-023 With macro MELODY_TEMPO_SEL_EN defined, the block SHALL add input port tempo (2 bits) and use P = TICK_CYCLES >> tempo. tempo SHALL be sampled only at tick boundaries and in LOAD.
REQ-024 Without MELODY_TEMPO_SEL_EN, the tempo port SHALL be absent and P = TICK_CYCLES.

Verification (TICK_CYCLES=4)
REQ-025 Release rst with run=1 -> note_start pulse with note=1 and melody_pos=0; gate high 28 cycles, low 4; then note_start with note=0.
REQ-026 Reach entry 2 (D, short) -> note=3, gate high exactly 12 cycles, then low 4.
REQ-027 Free-run from first note_start -> loop_done pulses exactly 512 cycles later, coincident with note_start, melody_pos=0, note=1.
REQ-028 run=0 for 10 cycles, 5 cycles into entry 0 -> gate 0 and all counters frozen; after resume, gate high a further 23 cycles.
REQ-029 restart during SPACE of entry 5 -> next cycle melody_pos=0, gate=0 (LOAD), then note_start with note=1; no loop_done.
REQ-030 MELODY_TEMPO_SEL_EN defined, tempo=1 -> short note gate high 6 cycles, space 2 cycles.
